audio_energy_tracker: RTL and testbench

Multi-channel, parametrised windowed-energy estimator for AC97 microphone samples, feeding the tracking logic. On each AC97 `ready` strobe it captures one signed sample per channel and squares the channels one per cycle through a single shared squarer. It accumulates per-channel energy over a programmable window, then publishes a thresholded, gain-scaled amplitude for every channel with a one-cycle `done` pulse. It also reports the loudest channel and flags dropped strobes and accumulator saturation.

---
 rtl/audio_energy_tracker.sv | 140 ++++++++++++++
 tb/tb_audio_energy_tracker.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_energy_tracker.sv
// Windowed per-channel energy estimator for AC97 samples: one shared squarer, one channel per cycle.
// Publishes thresholded, gain-scaled amplitudes with a done pulse; strobes arriving while busy are dropped.
module audio_energy_tracker #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 2,
  parameter int WINDOW    = 800,
  parameter int SHIFT     = 6,
  parameter int ACC_W     = 18,
  parameter int OUT_SHIFT = 2,
  parameter int THRESHOLD = 6500,
  parameter int GAIN      = 1,
  localparam int LW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ready,
  input  logic [CHANNELS*WIDTH-1:0] audio_in,
  output logic [CHANNELS*16-1:0]    amplitude,
  output logic [LW-1:0]             loudest,
  output logic                      active,
  output logic                      done,
  output logic                      overrun,
  output logic [CHANNELS-1:0]       saturated
);

  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam int SUM_W = ((2 * WIDTH > ACC_W) ? 2 * WIDTH : ACC_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH} state_t;

  state_t                      state_q;
  logic [CHANNELS*WIDTH-1:0]   hold_q;
  logic [LW-1:0]               ch_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [ACC_W-1:0]            acc_q [CHANNELS];
  logic [CHANNELS-1:0]         sat_q;

  logic [WIDTH-1:0]            smp;
  logic [WIDTH-1:0]            mag;
  logic [2*WIDTH-1:0]          sq_full;
  logic [2*WIDTH-1:0]          sq;
  logic [SUM_W-1:0]            sum;
  logic                        clip;
  logic [ACC_W-1:0]            acc_d;

  logic [CHANNELS*16-1:0]      amp_d;
  logic [LW-1:0]               loudest_d;
  logic                        active_d;

  // Unsigned magnitude: the most-negative code negates to 2^(WIDTH-1), which fits WIDTH unsigned bits.
  always_comb begin
    smp     = hold_q[int'(ch_q)*WIDTH +: WIDTH];
    mag     = smp[WIDTH-1] ? (~smp + 1'b1) : smp;
    sq_full = (2*WIDTH)'(mag) * (2*WIDTH)'(mag);
    sq      = sq_full >> SHIFT;
    sum     = SUM_W'(acc_q[ch_q]) + SUM_W'(sq);
    clip    = sum > SUM_W'(ACC_MAX);
    acc_d   = clip ? ACC_MAX : sum[ACC_W-1:0];
  end

  always_comb begin
    logic [15:0] metric;
    logic [47:0] prod;
    logic [15:0] amp_c;
    logic [15:0] best;
    amp_d     = '0;
    loudest_d = '0;
    active_d  = 1'b0;
    best      = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      metric = 16'(acc_q[c] >> OUT_SHIFT);
      prod   = 48'(metric) * 48'(GAIN);
      amp_c  = '0;
      if ({16'b0, metric} > 32'(THRESHOLD))
        amp_c = (prod > 48'd65535) ? 16'hFFFF : prod[15:0];
      amp_d[c*16 +: 16] = amp_c;
      // Strict greater-than keeps the lowest index on ties and 0 when all are zero.
      if (amp_c > best) begin
        best      = amp_c;
        loudest_d = LW'(c);
      end
      if (amp_c != 16'd0) active_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      ch_q      <= '0;
      cnt_q     <= '0;
      sat_q     <= '0;
      for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
      amplitude <= '0;
      loudest   <= '0;
      active    <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      saturated <= '0;
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ready) begin
            hold_q  <= audio_in;
            ch_q    <= '0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          overrun      <= ready;
          acc_q[ch_q]  <= acc_d;
          if (clip) sat_q[ch_q] <= 1'b1;
          if (ch_q == LW'(CHANNELS - 1)) begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= (cnt_q == CNT_W'(WINDOW - 1)) ? PUBLISH : IDLE;
          end else begin
            ch_q <= ch_q + 1'b1;
          end
        end
        PUBLISH: begin
          overrun   <= ready;
          amplitude <= amp_d;
          loudest   <= loudest_d;
          active    <= active_d;
          saturated <= sat_q;
          done      <= 1'b1;
          sat_q     <= '0;
          cnt_q     <= '0;
          for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_energy_tracker.sv
// Scoreboard bench for audio_energy_tracker: a reference model predicts each publish and overrun.
// Three instances cover default, GAIN=2 and WINDOW=1100 configurations.
`timescale 1ns/1ps
module tb_audio_energy_tracker;

  logic        clock = 1'b0;
  logic        reset;
  logic        ready;
  logic [15:0] audio_in;
  int          sel;
  int          cyc = 0;

  logic        ready0, ready1, ready2;
  logic [31:0] amp0, amp1, amp2;
  logic [0:0]  loud0, loud1, loud2;
  logic        act0, act1, act2, done0, done1, done2, ovr0, ovr1, ovr2;
  logic [1:0]  sat0, sat1, sat2;

  logic [31:0] amp_s;
  logic [0:0]  loud_s;
  logic        act_s, done_s, ovr_s;
  logic [1:0]  sat_s;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          cyc;
    logic [31:0] amp;
    logic [0:0]  loud;
    logic        act;
    logic [1:0]  sat;
  } exp_t;

  exp_t scb[$];
  int   ovq[$];

  int m_acc [2];
  bit m_sat [2];
  int m_cnt, m_free, m_gain, m_window;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign ready0 = ready && (sel == 0);
  assign ready1 = ready && (sel == 1);
  assign ready2 = ready && (sel == 2);

  audio_energy_tracker dut0 (
    .clock(clock), .reset(reset), .ready(ready0), .audio_in(audio_in),
    .amplitude(amp0), .loudest(loud0), .active(act0), .done(done0),
    .overrun(ovr0), .saturated(sat0));

  audio_energy_tracker #(.GAIN(2)) dut1 (
    .clock(clock), .reset(reset), .ready(ready1), .audio_in(audio_in),
    .amplitude(amp1), .loudest(loud1), .active(act1), .done(done1),
    .overrun(ovr1), .saturated(sat1));

  audio_energy_tracker #(.WINDOW(1100)) dut2 (
    .clock(clock), .reset(reset), .ready(ready2), .audio_in(audio_in),
    .amplitude(amp2), .loudest(loud2), .active(act2), .done(done2),
    .overrun(ovr2), .saturated(sat2));

  always_comb begin
    amp_s = amp0; loud_s = loud0; act_s = act0; done_s = done0; ovr_s = ovr0; sat_s = sat0;
    if (sel == 1) begin
      amp_s = amp1; loud_s = loud1; act_s = act1; done_s = done1; ovr_s = ovr1; sat_s = sat1;
    end else if (sel == 2) begin
      amp_s = amp2; loud_s = loud2; act_s = act2; done_s = done2; ovr_s = ovr2; sat_s = sat2;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_acc[c] = 0;
      m_sat[c] = 0;
    end
    m_cnt  = 0;
    m_free = 0;
  endtask

  task automatic model_strobe(input int t, input int a0, input int a1);
    int   s [2];
    int   mag, sq, metric, amp, best;
    exp_t e;
    if (t < m_free) begin
      ovq.push_back(t + 1);
      return;
    end
    s[0] = a0;
    s[1] = a1;
    for (int c = 0; c < 2; c++) begin
      mag = (s[c] < 0) ? -s[c] : s[c];
      sq  = (mag * mag) >> 6;
      m_acc[c] = m_acc[c] + sq;
      if (m_acc[c] > 262143) begin
        m_acc[c] = 262143;
        m_sat[c] = 1;
      end
    end
    m_cnt++;
    if (m_cnt == m_window) begin
      e.cyc = t + 4;
      e.amp = '0;
      e.loud = 1'b0;
      e.act = 1'b0;
      best = 0;
      for (int c = 0; c < 2; c++) begin
        metric = (m_acc[c] >> 2) & 16'hFFFF;
        amp = 0;
        if (metric > 6500) amp = (metric * m_gain > 65535) ? 65535 : metric * m_gain;
        e.amp[c*16 +: 16] = 16'(amp);
        if (amp > best) begin
          best = amp;
          e.loud = 1'(c);
        end
        if (amp != 0) e.act = 1'b1;
        e.sat[c] = m_sat[c];
      end
      scb.push_back(e);
      model_reset();
      m_free = t + 4;
    end else begin
      m_free = t + 3;
    end
  endtask

  task automatic strobe(input int a0, input int a1);
    @(posedge clock); #1;
    ready    = 1'b1;
    audio_in = {8'(a1), 8'(a0)};
    model_strobe(cyc, a0, a1);
    @(posedge clock); #1;
    ready = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic double_strobe(input int a0, input int a1);
    @(posedge clock); #1;
    ready    = 1'b1;
    audio_in = {8'(a1), 8'(a0)};
    model_strobe(cyc, a0, a1);
    @(posedge clock); #1;
    model_strobe(cyc, a0, a1);
    @(posedge clock); #1;
    ready = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic run(input int n, input int a0, input int a1);
    for (int i = 0; i < n; i++) strobe(a0, a1);
  endtask

  task automatic drain(input string tag);
    repeat (10) @(posedge clock);
    @(negedge clock);
    check({tag, "_drained"}, 64'(scb.size() + ovq.size()), 64'd0);
    scb.delete();
    ovq.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_amp"}, amp_s, 32'd0);
    check({tag, "_loud"}, loud_s, 1'b0);
    check({tag, "_act"}, act_s, 1'b0);
    check({tag, "_done"}, done_s, 1'b0);
    check({tag, "_ovr"}, ovr_s, 1'b0);
    check({tag, "_sat"}, sat_s, 2'b00);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (done_s || (scb.size() > 0 && scb[0].cyc == cyc)) begin
        check("done", done_s, (scb.size() > 0 && scb[0].cyc == cyc));
        if (scb.size() > 0 && scb[0].cyc == cyc) begin
          check("pub_amp", amp_s, scb[0].amp);
          check("pub_loud", loud_s, scb[0].loud);
          check("pub_act", act_s, scb[0].act);
          check("pub_sat", sat_s, scb[0].sat);
          void'(scb.pop_front());
        end
      end
      if (ovr_s || (ovq.size() > 0 && ovq[0] == cyc)) begin
        check("overrun", ovr_s, (ovq.size() > 0 && ovq[0] == cyc));
        if (ovq.size() > 0 && ovq[0] == cyc) void'(ovq.pop_front());
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ready = 1'b0;
    audio_in = '0;
    sel = 0;
    reset = 1'b1;
    m_gain = 1;
    m_window = 800;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("rst");
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_zero("post_rst");

    run(800, 100, 100);
    drain("p_const");
    check("const_amp", amp_s, {16'd31200, 16'd31200});
    check("const_loud", loud_s, 1'b0);
    check("const_act", act_s, 1'b1);

    run(800, 20, -128);
    drain("p_mixed");
    check("mixed_amp", amp_s, {16'd51200, 16'd0});
    check("mixed_loud", loud_s, 1'b1);
    check("mixed_sat", sat_s, 2'b00);

    double_strobe(100, 100);
    check("ovr_count", 64'(m_cnt), 64'd1);
    run(799, 100, 100);
    drain("p_ovr");
    check("ovr_amp", amp_s, {16'd31200, 16'd31200});

    run(400, 100, 100);
    @(posedge clock); #1;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_zero("mid_rst");
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_zero("mid_post_rst");
    run(800, 100, 100);
    drain("p_rst");
    check("rst_amp", amp_s, {16'd31200, 16'd31200});

    sel = 1;
    m_gain = 2;
    model_reset();
    run(800, -128, -128);
    drain("p_gain");
    check("gain_amp", amp_s, {16'd65535, 16'd65535});
    check("gain_loud", loud_s, 1'b0);

    sel = 2;
    m_gain = 1;
    m_window = 1100;
    model_reset();
    run(1100, -128, 0);
    drain("p_clip");
    check("clip_amp", amp_s, {16'd0, 16'd65535});
    check("clip_sat", sat_s, 2'b01);
    check("clip_act", act_s, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
